ddr5_dram_responder: RTL
========================

DDR5_DRAM_RESPONDER -- requirements
Module: ddr5_dram_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the DQ word width.
REQ-002 The block SHALL have parameter MEM_AW, default 8, meaning log2 of storage depth in words (minimum 5).
REQ-003 The block SHALL have parameter CL, default 4, meaning read latency in clk_mem cycles (minimum 1).
REQ-004 The block SHALL have parameters T_RCD, default 14, and T_RP, default 14, meaning ACT-to-RD/WR and PRE-to-ACT cycles.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk_mem  in  1  memory clock
- rst_n  in  1  asynchronous active-low reset
- ddr_cke  in  1  clock enable
- ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n  in  1 each  command strobes
- ddr_addr  in  18  row/column/precharge address
- ddr_bank  in  2  bank
- ddr_bank_group  in  2  bank group
- ddr_data_in  in  DATA_WIDTH  write data
- ddr_data_out  out  DATA_WIDTH  read data
- ddr_data_oe  out  1  read data valid/drive enable
- err_clr  in  1  clears sticky errors
- err_no_row  out  1  sticky flag: access to closed bank
- err_timing  out  1  sticky flag: timing or protocol violation
- ref_count  out  16  refresh counter

Function
REQ-006 The block SHALL decode {cs_n,ras_n,cas_n,we_n} as follows: 0011=ACT, 0101=RD, 0100=WR, 0010=PRE, 0001=REF; all other codes, including cs_n=1, SHALL be NOP.
REQ-007 The block SHALL ignore all commands while ddr_cke=0, with no state change other than timer countdown.
REQ-008 The block SHALL track 16 banks indexed {bank_group,bank}, each holding an open flag, an 18-bit row, and tRCD/tRP down-counters.
REQ-009 ACT SHALL open the bank, latch ddr_addr as row, and load tRCD with T_RCD.
REQ-010 PRE with ddr_addr[10]=1 SHALL close all banks; otherwise it SHALL close the addressed bank only; each closed bank SHALL load tRP with T_RP.
REQ-011 WR to an open bank with tRCD=0 SHALL write ddr_data_in, sampled in the same cycle as the command, to word {bank_group,bank,ddr_addr[MEM_AW-5:0]}; the row SHALL be ignored (aliasing is by design).
REQ-012 RD to an open bank with tRCD=0 SHALL present the word on ddr_data_out with ddr_data_oe=1 for exactly one cycle, CL cycles after the RD edge.
REQ-013 The read path SHALL be a CL-deep pipeline accepting RD on consecutive cycles.
REQ-014 RD of an address written in the immediately preceding cycle SHALL return the new data.
REQ-015 ddr_data_out SHALL be 0 whenever ddr_data_oe=0.
REQ-016 RD/WR to a closed bank SHALL set err_no_row and perform no access.
REQ-017 RD/WR with tRCD!=0 SHALL set err_timing and perform no access.
REQ-018 ACT to an open bank, or to a bank with tRP!=0, SHALL set err_timing; the ACT SHALL still take effect.
REQ-019 Errors SHALL be sticky until err_clr=1; an error and err_clr in the same cycle SHALL leave the flag set.
REQ-020 The tRCD/tRP counters SHALL decrement every cycle toward 0 and saturate at 0.

Reset
REQ-021 While rst_n=0, the block SHALL immediately force ddr_data_out=0, ddr_data_oe=0, err_no_row=0, err_timing=0, ref_count=0, all banks closed, all timers 0, and the read pipeline flushed.
REQ-022 Storage contents SHALL NOT be reset.
REQ-023 A read in flight at reset SHALL never produce an oe pulse.

Configuration
REQ-024 With DDR5_RESP_REFRESH_EN defined, REF with all banks closed and tRP=0 SHALL increment ref_count (wrapping 0xFFFF->0), and REF otherwise SHALL set err_timing without counting.
REQ-025 Without DDR5_RESP_REFRESH_EN, REF SHALL be treated as NOP and ref_count SHALL be tied to 0.

Structure
REQ-026 Package ddr5_pkg SHALL hold the command enum (ACT/RD/WR/PRE/REF/NOP) and the decode function.
REQ-027 Sub-module ddr5_bank_tracker SHALL hold per-bank open/row/tRCD/tRP state and be instantiated 16 times.

Verification
REQ-028 The bench SHALL check ACT bg0/b0 row 0x5, wait 14 cycles, WR col 3 data 0xDEADBEEF12345678, then RD col 3 -> oe pulse 4 cycles after RD with data_out=0xDEADBEEF12345678 and no errors.
REQ-029 The bench SHALL check RD to bank 2 never activated -> err_no_row=1, no oe pulse; then err_clr=1 -> err_no_row=0.
REQ-030 The bench SHALL check ACT followed by WR 5 cycles later -> err_timing=1, and a later valid RD to that address returns the prior contents.
REQ-031 The bench SHALL check PRE with ddr_addr=0x400 after opening banks 0 and 5, then ACT bank 5 after 3 cycles -> err_timing=1; ACT after 14 cycles -> no error.
REQ-032 The bench SHALL check four back-to-back RDs cols 0-3 -> four consecutive oe cycles with matching data; rst_n low mid-burst -> oe=0 immediately and no further pulses.
REQ-033 With DDR5_RESP_REFRESH_EN, the bench SHALL check REF with all banks closed -> ref_count=1, and REF with bank 1 open -> err_timing=1 and ref_count unchanged.

Source files
------------

// File: rtl/ddr5_pkg.sv
// Shared types for the DDR5 DRAM responder: command encoding, bank geometry
// and the strobe decoder.
package ddr5_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF
  } cmd_e;

  localparam int NUM_BANKS = 16;
  localparam int ROW_W     = 18;
  localparam int TMR_W     = 16;

  // strb = {cs_n, ras_n, cas_n, we_n}; anything with cs_n high falls to NOP
  function automatic cmd_e decode_cmd(input logic [3:0] strb);
    case (strb)
      4'b0011: decode_cmd = CMD_ACT;
      4'b0101: decode_cmd = CMD_RD;
      4'b0100: decode_cmd = CMD_WR;
      4'b0010: decode_cmd = CMD_PRE;
      4'b0001: decode_cmd = CMD_REF;
      default: decode_cmd = CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ddr5_bank_tracker.sv
// Per-bank state: open flag, active row and the tRCD / tRP countdown timers.
module ddr5_bank_tracker
  import ddr5_pkg::*;
#(
  parameter int T_RCD = 14,
  parameter int T_RP  = 14
) (
  input  logic             clk_mem,
  input  logic             rst_n,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             open_o,
  output logic [ROW_W-1:0] row_o,
  output logic             trcd_zero_o,
  output logic             trp_zero_o
);

  logic             open_q, open_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [TMR_W-1:0] trcd_q, trcd_d;
  logic [TMR_W-1:0] trp_q, trp_d;

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      row_q  <= '0;
      trcd_q <= '0;
      trp_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      trcd_q <= trcd_d;
      trp_q  <= trp_d;
    end
  end

  // Timers count down on every edge; a load on the same edge takes priority
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    trcd_d = (trcd_q != '0) ? trcd_q - TMR_W'(1) : trcd_q;
    trp_d  = (trp_q  != '0) ? trp_q  - TMR_W'(1) : trp_q;
    if (act_i) begin
      open_d = 1'b1;
      row_d  = row_i;
      trcd_d = TMR_W'(T_RCD);
    end
    if (pre_i) begin
      open_d = 1'b0;
      trp_d  = TMR_W'(T_RP);
    end
  end

  assign open_o      = open_q;
  assign row_o       = row_q;
  assign trcd_zero_o = (trcd_q == '0);
  assign trp_zero_o  = (trp_q == '0);

endmodule

// File: rtl/ddr5_dram_responder.sv
// Behavioural DDR5 DRAM responder: command decode, 16 bank trackers, word store
// with a CL-deep read pipeline. Refresh counting enabled by DDR5_RESP_REFRESH_EN.
module ddr5_dram_responder
  import ddr5_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 8,
  parameter int CL         = 4,
  parameter int T_RCD      = 14,
  parameter int T_RP       = 14
) (
  input  logic                  clk_mem,
  input  logic                  rst_n,
  input  logic                  ddr_cke,
  input  logic                  ddr_cs_n,
  input  logic                  ddr_ras_n,
  input  logic                  ddr_cas_n,
  input  logic                  ddr_we_n,
  input  logic [17:0]           ddr_addr,
  input  logic [1:0]            ddr_bank,
  input  logic [1:0]            ddr_bank_group,
  input  logic [DATA_WIDTH-1:0] ddr_data_in,
  output logic [DATA_WIDTH-1:0] ddr_data_out,
  output logic                  ddr_data_oe,
  input  logic                  err_clr,
  output logic                  err_no_row,
  output logic                  err_timing,
  output logic [15:0]           ref_count
);

  localparam int COL_W = MEM_AW - 4;
  localparam int DEPTH = 1 << MEM_AW;

  cmd_e                 cmd;
  logic [3:0]           bank_sel;
  logic [NUM_BANKS-1:0] act_hit, pre_hit;
  logic [NUM_BANKS-1:0] bank_open, bank_trcd_zero, bank_trp_zero;
  logic [ROW_W-1:0]     open_row_unused [NUM_BANKS];

  assign cmd      = ddr_cke ? decode_cmd({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}) : CMD_NOP;
  assign bank_sel = {ddr_bank_group, ddr_bank};

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign act_hit[gi] = (cmd == CMD_ACT) && (bank_sel == 4'(gi));
    assign pre_hit[gi] = (cmd == CMD_PRE) && (ddr_addr[10] || (bank_sel == 4'(gi)));

    ddr5_bank_tracker #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP)
    ) u_bank (
      .clk_mem     (clk_mem),
      .rst_n       (rst_n),
      .act_i       (act_hit[gi]),
      .pre_i       (pre_hit[gi]),
      .row_i       (ddr_addr),
      .open_o      (bank_open[gi]),
      .row_o       (open_row_unused[gi]),
      .trcd_zero_o (bank_trcd_zero[gi]),
      .trp_zero_o  (bank_trp_zero[gi])
    );
  end

  logic is_access, sel_open, sel_ready, rd_ok, wr_ok;
  logic set_no_row, set_timing, ref_bad;

  assign is_access  = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign sel_open   = bank_open[bank_sel];
  assign sel_ready  = bank_trcd_zero[bank_sel];
  assign rd_ok      = (cmd == CMD_RD) && sel_open && sel_ready;
  assign wr_ok      = (cmd == CMD_WR) && sel_open && sel_ready;
  assign set_no_row = is_access && !sel_open;
  // A flagged ACT still opens the bank; only the error is recorded
  assign set_timing = (is_access && sel_open && !sel_ready)
                    || ((cmd == CMD_ACT) && (sel_open || !bank_trp_zero[bank_sel]))
                    || ref_bad;

`ifdef DDR5_RESP_REFRESH_EN
  logic        all_idle;
  logic [15:0] ref_count_q, ref_count_d;

  assign all_idle    = ~|bank_open && &bank_trp_zero;
  assign ref_bad     = (cmd == CMD_REF) && !all_idle;
  assign ref_count_d = ((cmd == CMD_REF) && all_idle) ? ref_count_q + 16'd1 : ref_count_q;

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) ref_count_q <= '0;
    else        ref_count_q <= ref_count_d;
  end

  assign ref_count = ref_count_q;
`else
  assign ref_bad   = 1'b0;
  assign ref_count = '0;
`endif

  logic err_no_row_q, err_no_row_d, err_timing_q, err_timing_d;

  assign err_no_row_d = (err_no_row_q && !err_clr) || set_no_row;
  assign err_timing_d = (err_timing_q && !err_clr) || set_timing;

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      err_no_row_q <= 1'b0;
      err_timing_q <= 1'b0;
    end else begin
      err_no_row_q <= err_no_row_d;
      err_timing_q <= err_timing_d;
    end
  end

  assign err_no_row = err_no_row_q;
  assign err_timing = err_timing_q;

  // Storage is deliberately not reset; the row never enters the word address
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic [MEM_AW-1:0]     mem_addr;

  assign mem_addr = {bank_sel, ddr_addr[COL_W-1:0]};

  always_ff @(posedge clk_mem) begin
    if (wr_ok) mem_q[mem_addr] <= ddr_data_in;
    if (rd_ok) mem_rdata_q <= mem_q[mem_addr];
  end

  // RAM output register plus CL-1 delay stages, then a gated output register
  logic [DATA_WIDTH-1:0] rd_data;

  if (CL == 1) begin : g_cl1
    assign rd_data = mem_rdata_q;
  end else begin : g_dly
    logic [DATA_WIDTH-1:0] dly_q [CL-1];
    always_ff @(posedge clk_mem) begin
      dly_q[0] <= mem_rdata_q;
      for (int i = 1; i < CL - 1; i++) dly_q[i] <= dly_q[i-1];
    end
    assign rd_data = dly_q[CL-2];
  end

  logic [CL-1:0]         rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_oe_q;

  assign rd_vld_d   = CL'({rd_vld_q, rd_ok});
  assign data_out_d = rd_vld_q[CL-1] ? rd_data : '0;

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      data_out_q <= data_out_d;
      data_oe_q  <= rd_vld_q[CL-1];
    end
  end

  assign ddr_data_out = data_out_q;
  assign ddr_data_oe  = data_oe_q;

endmodule
